dcache_responder: RTL

//  CPU-facing responder for data-side load/store requests: direct-mapped, one word per line,

---
 rtl/dcache_responder_pkg.sv | 13 +
 rtl/dcache_responder_line_store.sv | 46 ++++
 rtl/dcache_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared types and defaults for the data-side cache responder.
package dcache_responder_pkg;

  typedef enum logic [1:0] {
    DC_IDLE,
    DC_LOOKUP,
    DC_MEM,
    DC_FLUSH
  } dc_state_t;

  localparam int unsigned DC_LINES_DEFAULT = 64;

endpackage

// File: rtl/dcache_responder_line_store.sv
// Direct-mapped line storage: valid bits (async reset), tag and data arrays,
// combinational hit lookup, one write port and one clear-index port.
module dcache_line_store #(
  parameter int unsigned LINES = 64,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
    end
  end

  // Tag/data contents are meaningless while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_data = data[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
// Optional load hit/miss counters: define DCACHE_STATS_EN.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int unsigned LINES  = DC_LINES_DEFAULT,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  dc_state_t          state;
  logic               l_we;
  logic [ADDR_W-3:0]  l_word;
  logic [31:0]        l_wdata;
  logic [IDX_W-1:0]   flush_cnt;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [31:0]        line_data;
  logic               ls_wr_en;
  logic [31:0]        ls_wr_data;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign idx = l_word[IDX_W-1:0];
  assign tag = l_word[ADDR_W-3:IDX_W];

  // Store hits refresh the line in LOOKUP; load misses install on the ack edge.
  always_comb begin
    ls_wr_en   = 1'b0;
    ls_wr_data = l_wdata;
    if (state == DC_LOOKUP && l_we && hit) begin
      ls_wr_en = 1'b1;
    end else if (state == DC_MEM && mem_ack && !l_we) begin
      ls_wr_en   = 1'b1;
      ls_wr_data = mem_rdata;
    end
  end

  dcache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_tag  (tag),
    .hit     (hit),
    .rd_data (line_data),
    .wr_en   (ls_wr_en),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data (ls_wr_data),
    .clr_en  (state == DC_FLUSH),
    .clr_idx (flush_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DC_IDLE;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      l_we       <= 1'b0;
      l_word     <= '0;
      l_wdata    <= '0;
      flush_cnt  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        DC_IDLE: begin
          if (cpu_flush) begin
            cpu_ready <= 1'b0;
            flush_cnt <= '0;
            state     <= DC_FLUSH;
          end else if (cpu_req) begin
            l_we      <= cpu_we;
            l_word    <= cpu_addr[ADDR_W-1:2];
            l_wdata   <= cpu_wdata;
            cpu_ready <= 1'b0;
            state     <= DC_LOOKUP;
          end
        end
        DC_LOOKUP: begin
          if (!l_we && hit) begin
            cpu_rdata  <= line_data;
            cpu_rvalid <= 1'b1;
            cpu_ready  <= 1'b1;
            state      <= DC_IDLE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= l_we;
            mem_addr  <= {l_word, 2'b00};
            mem_wdata <= l_wdata;
            state     <= DC_MEM;
          end
        end
        DC_MEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            cpu_rvalid <= 1'b1;
            cpu_ready  <= 1'b1;
            cpu_rdata  <= l_we ? '0 : mem_rdata;
            state      <= DC_IDLE;
          end
        end
        DC_FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == IDX_W'(LINES - 1)) begin
            flush_done <= 1'b1;
            cpu_ready  <= 1'b1;
            state      <= DC_IDLE;
          end
        end
        default: state <= DC_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == DC_LOOKUP && !l_we) begin
      if (hit) hit_count  <= hit_count + 1'b1;
      else     miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
